sb_rr_arb: RTL and testbench
============================

# sb_rr_arb

Parametrised successor to the two-master system bus: arbitrates N masters (core load/store unit, DMA, debug) onto one word-wide data memory port using round-robin grant and a request/ack handshake. Byte and halfword accesses are handled internally: sub-word reads are extracted and sign/zero-extended, and sub-word writes become read-modify-write sequences. The memory itself is only ever driven with full-word reads and writes. It sits between the core's memory-stage outputs and `dmem` in the SoC top.

## Interface
- `N_MASTERS`, default 2: number of master ports. Must be ≥ 1.
- `AW`, default 32: address width. Data width is fixed at 32 bits and byte mask width is fixed at 4 bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m_req` in N: per-master request. Held with all fields stable until that master's ack.
- `m_we` in N: 1 = write, 0 = read.
- `m_un_sign` in N: 1 = zero-extend sub-word read data, 0 = sign-extend it.
- `m_byte_mask` in 4·N: lane select. Legal values are 0001, 0010, 0100, 1000, 0011, 1100 and 1111.
- `m_addr` in AW·N: byte address. Bits [1:0] are ignored.
- `m_wdata` in 32·N: write data, low-aligned (byte in [7:0], half in [15:0]).
- `m_ack_o` out N: one-cycle completion pulse, one-hot or zero.
- `m_err_o` out 1: pulses together with `m_ack_o` when the request used an illegal mask.
- `m_rdata_o` out 32: shared read data. Valid in the read-ack cycle and held until the next read ack.
- `s_rw_o` out 1: slave strobe, 1 = write this cycle.
- `s_addr_o` out AW: word address, {addr[AW-1:2], 2'b00}.
- `s_wdata_o` out 32: full-word write data.
- `s_rdata` in 32: slave read data. Valid one cycle after the address is presented (synchronous read).

## Operation
- State machine has four states: IDLE, RD_ADDR, RD_DATA, WR.
- Arbitration happens only in IDLE. The winner is the first asserted `m_req` scanning from `ptr+1` upward, wrapping modulo N. On a grant, `ptr` takes the winner index and the winner's fields are latched (gidx, we, un_sign, mask, addr, wdata).
- State transitions out of IDLE with a grant:
  - read → RD_ADDR
  - write with mask 1111 → WR
  - write with any other mask → RD_ADDR
- RD_ADDR → RD_DATA unconditionally.
- RD_DATA behaviour:
  - Read: `m_rdata_o` takes the selected lanes, shifted down to bit 0 and extended per un_sign to 32 bits. `m_ack_o[gidx]` pulses. Next state is IDLE.
  - Write: the merge word is captured as `s_rdata` with the masked lanes replaced by the shifted `m_wdata`. Next state is WR.
- WR: `s_rw_o`=1, `s_wdata_o` = merged word (or the raw wdata for mask 1111), `m_ack_o[gidx]` pulses. Next state is IDLE.
- Lane shifts by mask:
  - 0001/0011/1111 → 0
  - 0010 → 8
  - 0100/1100 → 16
  - 1000 → 24
- Illegal mask: the access is performed as a full word (1111), and `m_err_o` pulses with the ack.
- `s_addr_o` carries the latched word address in every non-IDLE state. In IDLE it is 0 and `s_rw_o`=0.
- Request rule: a master must drop `m_req` in the cycle after its ack, or hold it to request again. A master whose request was already latched is not re-sampled. Changing its fields before the ack is a protocol violation and its result is undefined.

## Timing
- Reset (synchronous) sets:
  - state = IDLE, `ptr` = N-1 (so master 0 wins first)
  - `m_ack_o` = 0, `m_err_o` = 0, `m_rdata_o` = 0
  - `s_rw_o` = 0, `s_addr_o` = 0, `s_wdata_o` = 0
- Reset mid-transaction aborts with no ack and no slave write. A WR cycle coinciding with `rst` must not assert `s_rw_o`.
- Latency, counted from the cycle a request is seen in IDLE (cycle 0):
  - Read: ack in cycle 2.
  - Full-word write: ack and slave write in cycle 1.
  - Partial write: ack and slave write in cycle 3.
- Throughput: IDLE occupies at least one cycle between transactions. Back-to-back reads from the same master complete every 3 cycles; full-word writes every 2 cycles.
- Simultaneous requests in IDLE: exactly one grant is made, per round-robin. Others wait and no master starves: a waiting master is served within N transactions.
- N_MASTERS = 1 degenerates to pass-through with the same latencies.

## Test plan
- Reset, then master 0 reads at 0x100 with memory 0x8899AABB, mask 1000, un_sign=0 → ack in cycle 2, `m_rdata_o` = 0xFFFFFF88. Repeat with un_sign=1 → 0x00000088.
- Master 1 half-write of 0x1234, mask 1100, to word 0x5566_7788 → slave read cycle 1, `s_rw_o`=1 with `s_wdata_o` = 0x1234_7788 in cycle 3, ack in cycle 3.
- Both masters hold `m_req` continuously with full-word writes → grants alternate 0, 1, 0, 1, starting with 0 after reset, with an ack every 2 cycles.
- Full-word write 0xDEADBEEF then read of the same address → write ack in cycle 1, no slave read issued, subsequent read returns 0xDEADBEEF.
- Illegal mask 0110 on a read → full word returned, `m_err_o` = 1 in the ack cycle only.
- `rst` asserted in the RD_DATA cycle of a partial write → no `s_rw_o` pulse, no ack, memory unchanged, and a re-issued request completes normally with master 0 priority.

Source files
------------

// File: rtl/sb_rr_arb_if.sv
// Bus bundle for the round-robin data-memory arbiter.
// "slave" is the arbiter's view: it serves the masters and drives the memory port.
// "master" is the environment's view: requesters plus the word-wide memory.
interface sb_rr_arb_if #(
    parameter int N_MASTERS = 2,
    parameter int AW        = 32
);
    logic [N_MASTERS-1:0]    m_req;
    logic [N_MASTERS-1:0]    m_we;
    logic [N_MASTERS-1:0]    m_un_sign;
    logic [4*N_MASTERS-1:0]  m_byte_mask;
    logic [AW*N_MASTERS-1:0] m_addr;
    logic [32*N_MASTERS-1:0] m_wdata;
    logic [N_MASTERS-1:0]    m_ack_o;
    logic                    m_err_o;
    logic [31:0]             m_rdata_o;
    logic                    s_rw_o;
    logic [AW-1:0]           s_addr_o;
    logic [31:0]             s_wdata_o;
    logic [31:0]             s_rdata;

    modport slave (
        input  m_req, m_we, m_un_sign, m_byte_mask, m_addr, m_wdata, s_rdata,
        output m_ack_o, m_err_o, m_rdata_o, s_rw_o, s_addr_o, s_wdata_o
    );

    modport master (
        output m_req, m_we, m_un_sign, m_byte_mask, m_addr, m_wdata, s_rdata,
        input  m_ack_o, m_err_o, m_rdata_o, s_rw_o, s_addr_o, s_wdata_o
    );
endinterface

// File: rtl/sb_rr_arb.sv
// Round-robin arbiter of N masters onto one word-wide synchronous-read memory.
// Sub-word reads are lane-extracted and extended; sub-word writes become
// read-modify-write. The memory only ever sees full-word accesses.
module sb_rr_arb #(
    parameter int N_MASTERS = 2,
    parameter int AW        = 32
) (
    input  logic       clk,
    input  logic       rst,
    sb_rr_arb_if.slave bus
);
    localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;

    state_t        state_reg, state_next;
    // Last winner; also serves as the round-robin pointer while in IDLE.
    logic [PW-1:0] gidx_reg;
    logic          we_reg, un_sign_reg, err_reg;
    logic [3:0]    mask_reg;
    logic [AW-3:0] waddr_reg;
    logic [31:0]   wdata_reg, merge_reg, rdata_reg;

    logic [3:0]    mask_arr  [N_MASTERS];
    logic [AW-3:0] waddr_arr [N_MASTERS];
    logic [31:0]   wdata_arr [N_MASTERS];

    logic          grant_valid;
    logic [PW-1:0] grant_idx;
    int            scan_idx;
    logic [3:0]    grant_mask_raw, grant_mask;
    logic          grant_legal;

    logic          ack_pulse, s_rw, capture_en;
    logic [4:0]    lane_shift;
    logic [31:0]   lane_bits, rd_shifted, rd_ext, wr_shifted, merge_next;

    function automatic logic mask_legal(input logic [3:0] m);
        case (m)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Unpack the flattened per-master buses and fan the ack out one-hot.
    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_port
            assign mask_arr[gi]    = bus.m_byte_mask[4*gi +: 4];
            assign waddr_arr[gi]   = bus.m_addr[AW*gi+2 +: AW-2];
            assign wdata_arr[gi]   = bus.m_wdata[32*gi +: 32];
            assign bus.m_ack_o[gi] = ack_pulse && (gidx_reg == PW'(gi));
        end
    endgenerate

    // Round-robin pick: first request scanning upward from the last winner + 1.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            scan_idx = int'(gidx_reg) + i;
            if (scan_idx >= N_MASTERS) begin
                scan_idx = scan_idx - N_MASTERS;
            end
            if (!grant_valid && bus.m_req[PW'(scan_idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(scan_idx);
            end
        end
        grant_mask_raw = mask_arr[grant_idx];
        grant_legal    = mask_legal(grant_mask_raw);
        // An illegal mask is carried out as a full-word access.
        grant_mask     = grant_legal ? grant_mask_raw : 4'b1111;
    end

    // Lane alignment, read extension and write merge for the latched access.
    always_comb begin
        case (mask_reg)
            4'b0010:          lane_shift = 5'd8;
            4'b0100, 4'b1100: lane_shift = 5'd16;
            4'b1000:          lane_shift = 5'd24;
            default:          lane_shift = 5'd0;
        endcase
        lane_bits  = {{8{mask_reg[3]}}, {8{mask_reg[2]}}, {8{mask_reg[1]}}, {8{mask_reg[0]}}};
        rd_shifted = bus.s_rdata >> lane_shift;
        case (mask_reg)
            4'b0011, 4'b1100: rd_ext = {{16{rd_shifted[15] & ~un_sign_reg}}, rd_shifted[15:0]};
            4'b1111:          rd_ext = rd_shifted;
            default:          rd_ext = {{24{rd_shifted[7] & ~un_sign_reg}}, rd_shifted[7:0]};
        endcase
        wr_shifted = wdata_reg << lane_shift;
        merge_next = (bus.s_rdata & ~lane_bits) | (wr_shifted & lane_bits);
    end

    // Next-state and strobe decode; reset suppresses ack and slave write.
    always_comb begin
        state_next = state_reg;
        ack_pulse  = 1'b0;
        s_rw       = 1'b0;
        capture_en = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    if (bus.m_we[grant_idx] && grant_mask == 4'b1111) begin
                        state_next = WR;
                    end else begin
                        state_next = RD_ADDR;
                    end
                end
            end
            RD_ADDR: state_next = RD_DATA;
            RD_DATA: begin
                capture_en = 1'b1;
                ack_pulse  = !we_reg && !rst;
                state_next = we_reg ? WR : IDLE;
            end
            WR: begin
                ack_pulse  = !rst;
                s_rw       = !rst;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Grant latch and read/merge capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            gidx_reg    <= PW'(N_MASTERS - 1);
            we_reg      <= 1'b0;
            un_sign_reg <= 1'b0;
            err_reg     <= 1'b0;
            mask_reg    <= 4'b1111;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            merge_reg   <= '0;
            rdata_reg   <= '0;
        end else begin
            if (state_reg == IDLE && grant_valid) begin
                gidx_reg    <= grant_idx;
                we_reg      <= bus.m_we[grant_idx];
                un_sign_reg <= bus.m_un_sign[grant_idx];
                err_reg     <= !grant_legal;
                mask_reg    <= grant_mask;
                waddr_reg   <= waddr_arr[grant_idx];
                wdata_reg   <= wdata_arr[grant_idx];
            end
            if (capture_en) begin
                if (we_reg) begin
                    merge_reg <= merge_next;
                end else begin
                    rdata_reg <= rd_ext;
                end
            end
        end
    end

    assign bus.m_err_o   = ack_pulse && err_reg;
    // Read data is live in the ack cycle and held afterwards.
    assign bus.m_rdata_o = (state_reg == RD_DATA && !we_reg) ? rd_ext : rdata_reg;
    assign bus.s_rw_o    = s_rw;
    assign bus.s_addr_o  = (state_reg == IDLE) ? '0 : {waddr_reg, 2'b00};
    assign bus.s_wdata_o = (state_reg != WR)     ? '0 :
                           (mask_reg == 4'b1111) ? wdata_reg : merge_reg;
endmodule

// File: tb/tb_sb_rr_arb.sv
// Bench for sb_rr_arb: directed scenarios with literal expectations, then
// randomized traffic from three masters against a transaction-level model.
module tb_sb_rr_arb;
    localparam int N  = 3;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sb_rr_arb_if #(.N_MASTERS(N), .AW(AW)) bus ();
    sb_rr_arb #(.N_MASTERS(N), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Word memory behind the slave port, 16 words at 0x100..0x13C.
    logic [31:0] mem [16];
    logic [31:0] rdata_q;
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (bus.s_rw_o) mem[bus.s_addr_o[5:2]] <= bus.s_wdata_o;
        rdata_q <= mem[bus.s_addr_o[5:2]];
    end
    assign bus.s_rdata = rdata_q;

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [16];
    logic [31:0] hold_rdata;
    int          md_busy, md_t, md_lat, md_w, md_last, md_c, n_txn;
    logic        md_found, md_we, md_uns, md_err;
    logic [3:0]  md_mask;
    logic [31:0] md_addr, md_wdata, md_exp;

    function automatic logic legal(input logic [3:0] m);
        return m inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    endfunction

    function automatic int low_lane(input logic [3:0] m);
        for (int b = 0; b < 4; b++) if (m[b]) return b;
        return 0;
    endfunction

    function automatic logic [31:0] read_view(input logic [31:0] word, input logic [3:0] m, input logic uns);
        int lo = low_lane(m) * 8;
        int w  = $countones(m) * 8;
        logic [63:0] keep = (64'd1 << w) - 64'd1;
        logic [63:0] v = ({32'd0, word} >> lo) & keep;
        if (!uns && w < 32 && v[w-1]) v = v | ~keep;
        return v[31:0];
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] word, input logic [3:0] m, input logic [31:0] wd);
        logic [31:0] r = word;
        int lo = low_lane(m);
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*(b-lo) +: 8];
        return r;
    endfunction

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (pre_en) ref_mem[pre_idx] = pre_val;
        if (rst) begin
            check("rst_ack", 32'(bus.m_ack_o), 32'd0);
            check("rst_err", 32'(bus.m_err_o), 32'd0);
            check("rst_srw", 32'(bus.s_rw_o), 32'd0);
            md_busy = 0;
            md_last = N - 1;
            hold_rdata = '0;
        end else if (md_busy == 0) begin
            check("idle_ack", 32'(bus.m_ack_o), 32'd0);
            check("idle_err", 32'(bus.m_err_o), 32'd0);
            check("idle_srw", 32'(bus.s_rw_o), 32'd0);
            check("idle_saddr", bus.s_addr_o, 32'd0);
            check("idle_rdata", bus.m_rdata_o, hold_rdata);
            md_found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                md_c = (md_last + k) % N;
                if (!md_found && bus.m_req[md_c]) begin
                    md_found = 1'b1;
                    md_w     = md_c;
                    md_we    = bus.m_we[md_c];
                    md_uns   = bus.m_un_sign[md_c];
                    md_err   = !legal(bus.m_byte_mask[4*md_c +: 4]);
                    md_mask  = md_err ? 4'hF : bus.m_byte_mask[4*md_c +: 4];
                    md_addr  = bus.m_addr[AW*md_c +: AW];
                    md_wdata = bus.m_wdata[32*md_c +: 32];
                end
            end
            if (md_found) begin
                md_last = md_w;
                md_busy = 1;
                md_t    = 0;
                md_lat  = !md_we ? 2 : (md_mask == 4'hF ? 1 : 3);
            end
        end else begin
            md_t++;
            check("busy_saddr", bus.s_addr_o, {md_addr[31:2], 2'b00});
            if (md_t < md_lat) begin
                check("wait_ack", 32'(bus.m_ack_o), 32'd0);
                check("wait_srw", 32'(bus.s_rw_o), 32'd0);
                check("wait_rdata", bus.m_rdata_o, hold_rdata);
            end else begin
                check("ack_onehot", 32'(bus.m_ack_o), 32'd1 << md_w);
                check("ack_err", 32'(bus.m_err_o), 32'(md_err));
                if (!md_we) begin
                    md_exp = read_view(ref_mem[md_addr[5:2]], md_mask, md_uns);
                    check("rd_data", bus.m_rdata_o, md_exp);
                    check("rd_srw", 32'(bus.s_rw_o), 32'd0);
                    hold_rdata = md_exp;
                end else begin
                    md_exp = merge_word(ref_mem[md_addr[5:2]], md_mask, md_wdata);
                    check("wr_srw", 32'(bus.s_rw_o), 32'd1);
                    check("wr_wdata", bus.s_wdata_o, md_exp);
                    ref_mem[md_addr[5:2]] = md_exp;
                end
                n_txn++;
                $display("txn %0d: m%0d %s addr=%08h mask=%h data=%08h err=%0b",
                         n_txn, md_w, md_we ? "WR" : "RD", md_addr, md_mask, md_exp, md_err);
                md_busy = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] legal_masks [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    task automatic preload(input int idx, input logic [31:0] val);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_idx = 4'(idx); pre_val = val;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic drive(input int m, input logic we, input logic uns, input logic [3:0] mk,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.m_req[m]             = 1'b1;
        bus.m_we[m]              = we;
        bus.m_un_sign[m]         = uns;
        bus.m_byte_mask[4*m +: 4] = mk;
        bus.m_addr[AW*m +: AW]   = addr;
        bus.m_wdata[32*m +: 32]  = wd;
    endtask

    task automatic drive_random(input int m);
        logic [3:0] mk;
        if ($urandom_range(0, 9) == 0) mk = 4'($urandom_range(0, 15));
        else mk = legal_masks[$urandom_range(0, 6)];
        drive(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mk,
              32'h100 | 32'($urandom_range(0, 63)), $urandom);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.m_req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ack", 32'(bus.m_ack_o), 32'd0);
        check("reset_err", 32'(bus.m_err_o), 32'd0);
        check("reset_rdata", bus.m_rdata_o, 32'd0);
        check("reset_srw", 32'(bus.s_rw_o), 32'd0);
        check("reset_saddr", bus.s_addr_o, 32'd0);
        check("reset_swdata", bus.s_wdata_o, 32'd0);
    endtask

    // One request from one master; latency counted from the request's first cycle.
    task automatic run_one(input int m, input logic we, input logic uns, input logic [3:0] mk,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic err);
        @(posedge clk); #1;
        drive(m, we, uns, mk, addr, wd);
        lat = -1; rd = '0; err = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.m_ack_o[m]) begin
                lat = c; rd = bus.m_rdata_o; err = bus.m_err_o;
                break;
            end
        end
        @(posedge clk); #1;
        bus.m_req[m] = 1'b0;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        err;
    logic [N-1:0] ack_s;
    int          w_arr [4];
    int          c_arr [4];
    int          n_ack, first_w, done1, saw;

    initial begin
        bus.m_req = '0; bus.m_we = '0; bus.m_un_sign = '0;
        bus.m_byte_mask = '0; bus.m_addr = '0; bus.m_wdata = '0;
        n_txn = 0;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        do_reset();

        // Sub-word signed / unsigned byte read.
        preload(0, 32'h8899AABB);
        run_one(0, 1'b0, 1'b0, 4'b1000, 32'h100, 32'd0, lat, rd, err);
        check("rd_b3_lat", lat, 2);
        check("rd_b3_signed", rd, 32'hFFFFFF88);
        run_one(0, 1'b0, 1'b1, 4'b1000, 32'h100, 32'd0, lat, rd, err);
        check("rd_b3_unsigned", rd, 32'h00000088);

        // Partial (upper half) write via read-modify-write.
        preload(1, 32'h55667788);
        run_one(1, 1'b1, 1'b0, 4'b1100, 32'h104, 32'h1234, lat, rd, err);
        check("hw_wr_lat", lat, 3);
        check("hw_wr_mem", mem[1], 32'h12347788);

        // Two masters hold full-word writes: alternate grants, ack every 2 cycles.
        do_reset();
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 4'hF, 32'h110, 32'h11111111);
        drive(1, 1'b1, 1'b0, 4'hF, 32'h114, 32'h22222222);
        n_ack = 0;
        for (int i = 0; i < 4; i++) begin w_arr[i] = -1; c_arr[i] = -1; end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int m = 0; m < N; m++) begin
                if (bus.m_ack_o[m] && n_ack < 4) begin
                    w_arr[n_ack] = m; c_arr[n_ack] = c; n_ack++;
                end
            end
        end
        @(posedge clk); #1;
        bus.m_req = '0;
        for (int i = 0; i < 4; i++) begin
            check("b2b_winner", w_arr[i], i % 2);
            check("b2b_cycle", c_arr[i], 2*i + 1);
        end

        // Full-word write then read-back.
        run_one(0, 1'b1, 1'b0, 4'hF, 32'h108, 32'hDEADBEEF, lat, rd, err);
        check("fw_wr_lat", lat, 1);
        run_one(0, 1'b0, 1'b0, 4'hF, 32'h108, 32'd0, lat, rd, err);
        check("fw_rd_lat", lat, 2);
        check("fw_rd_data", rd, 32'hDEADBEEF);

        // Illegal mask 0110 on a read: full word plus error pulse.
        run_one(1, 1'b0, 1'b0, 4'b0110, 32'h100, 32'd0, lat, rd, err);
        check("ill_rd_data", rd, 32'h8899AABB);
        check("ill_rd_err", 32'(err), 32'd1);

        // Reset during RD_DATA of a partial write aborts it.
        preload(3, 32'hCAFEF00D);
        saw = 0;
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 4'b1100, 32'h10C, 32'h0000BEEF);
        @(negedge clk); saw |= int'(|bus.m_ack_o) | int'(bus.s_rw_o);
        @(negedge clk); saw |= int'(|bus.m_ack_o) | int'(bus.s_rw_o);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.m_req[1] = 1'b0;
        @(negedge clk); saw |= int'(|bus.m_ack_o) | int'(bus.s_rw_o);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); saw |= int'(|bus.m_ack_o) | int'(bus.s_rw_o);
        @(posedge clk); #1;
        check("abort_no_ack_or_write", saw, 0);
        check("abort_mem_kept", mem[3], 32'hCAFEF00D);

        // Re-issue alongside a master-0 read: master 0 wins first after reset.
        drive(0, 1'b0, 1'b0, 4'hF, 32'h100, 32'd0);
        drive(1, 1'b1, 1'b0, 4'b1100, 32'h10C, 32'h0000BEEF);
        first_w = -1; done1 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ack_s = bus.m_ack_o;
            @(posedge clk); #1;
            if (ack_s[0]) begin bus.m_req[0] = 1'b0; if (first_w < 0) first_w = 0; end
            if (ack_s[1]) begin bus.m_req[1] = 1'b0; if (first_w < 0) first_w = 1; done1 = 1; end
        end
        check("reissue_first_winner", first_w, 0);
        check("reissue_done", done1, 1);
        check("reissue_mem", mem[3], 32'hBEEFF00D);

        // Randomized traffic from all masters with occasional resets.
        for (int it = 0; it < 1500; it++) begin
            @(negedge clk);
            ack_s = bus.m_ack_o;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 299) == 0);
            for (int m = 0; m < N; m++) begin
                if (ack_s[m] || !bus.m_req[m]) begin
                    if ($urandom_range(0, 2) != 0) drive_random(m);
                    else bus.m_req[m] = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.m_req = '0;
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
